// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single-ported synchronous memory.
// Optional round-robin arbitration via `define MEM_ARB_RR_EN; fixed data-first priority otherwise.
module mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_valid,
    input  logic [31:0] if_req_addr,
    output logic        if_req_ready,
    output logic        if_rsp_valid,
    output logic [31:0] if_rsp_data,
    input  logic        d_req_valid,
    input  logic        d_req_we,
    input  logic [31:0] d_req_addr,
    input  logic [31:0] d_req_wdata,
    output logic        d_req_ready,
    output logic        d_rsp_valid,
    output logic [31:0] d_rsp_data,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef struct packed {
        logic owner_d;
        logic we;
    } rsp_tag_t;

    logic     gnt_d, gnt_i;
    logic     vld_pipe [1:0];
    rsp_tag_t tag_q;

`ifdef MEM_ARB_RR_EN
    // Remembers who won the most recent acceptance; reset to data so fetch wins first.
    logic last_d;

    always_comb gnt_d = !rst && d_req_valid && (!if_req_valid || !last_d);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_d <= 1'b1;
        else if (gnt_d || gnt_i)
            last_d <= gnt_d;
    end
`else
    always_comb gnt_d = !rst && d_req_valid;
`endif

    always_comb gnt_i = !rst && if_req_valid && !gnt_d;

    assign if_req_ready = gnt_i;
    assign d_req_ready  = gnt_d;
    assign mem_addr     = gnt_d ? {2'b00, d_req_addr[31:2]} : {2'b00, if_req_addr[31:2]};
    assign mem_we       = gnt_d && d_req_we;
    assign mem_wdata    = d_req_wdata;

    always_comb vld_pipe[0] = gnt_d || gnt_i;

    // Response stage: memory data lands one cycle after acceptance, so only the tag is kept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe[1] <= 1'b0;
            tag_q       <= '0;
        end else begin
            vld_pipe[1] <= vld_pipe[0];
            tag_q       <= '{owner_d: gnt_d, we: gnt_d && d_req_we};
        end
    end

    assign if_rsp_valid = vld_pipe[1] && !tag_q.owner_d;
    assign d_rsp_valid  = vld_pipe[1] &&  tag_q.owner_d;
    assign if_rsp_data  = if_rsp_valid ? mem_rdata : 32'h0;
    assign d_rsp_data   = (d_rsp_valid && !tag_q.we) ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a synchronous-read memory model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_valid;
    logic [31:0] if_req_addr;
    logic        if_req_ready;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_data;
    logic        d_req_valid;
    logic        d_req_we;
    logic [31:0] d_req_addr;
    logic [31:0] d_req_wdata;
    logic        d_req_ready;
    logic        d_rsp_valid;
    logic [31:0] d_rsp_data;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem   [0:255];
    logic [31:0] model [0:255];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
        .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
        .d_req_wdata(d_req_wdata), .d_req_ready(d_req_ready),
        .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
        mem_rdata <= mem[mem_addr[7:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [31:0] ia,
                         input logic dv, input logic dwe, input logic [31:0] da, input logic [31:0] dw);
        @(negedge clk);
        if_req_valid = iv; if_req_addr = ia;
        d_req_valid = dv; d_req_we = dwe; d_req_addr = da; d_req_wdata = dw;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]   = 32'hC0DE_0000 | i;
            model[i] = 32'hC0DE_0000 | i;
        end
        mem_rdata = '0;
        rst = 1'b1;
        if_req_valid = 1'b1; if_req_addr = 32'h4;
        d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 32'h8; d_req_wdata = 32'h1234;
        #1;
        chk("rst_if_ready", {31'b0, if_req_ready}, 32'd0);
        chk("rst_d_ready",  {31'b0, d_req_ready},  32'd0);
        chk("rst_mem_we",   {31'b0, mem_we},       32'd0);
        chk("rst_rsp_vld",  {30'b0, if_rsp_valid, d_rsp_valid}, 32'd0);
        chk("rst_rsp_data", if_rsp_data | d_rsp_data, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        if_req_valid = 1'b0; d_req_valid = 1'b0; d_req_we = 1'b0;

        // Single fetch
        drive(1, 32'h8, 0, 0, 0, 0);
        chk("f_if_ready", {31'b0, if_req_ready}, 32'd1);
        chk("f_d_ready",  {31'b0, d_req_ready},  32'd0);
        chk("f_mem_addr", mem_addr, 32'h2);
        drive(0, 0, 0, 0, 0, 0);
        chk("f_rsp_valid", {31'b0, if_rsp_valid}, 32'd1);
        chk("f_rsp_data",  if_rsp_data, model[2]);
        chk("f_d_rsp_quiet", {31'b0, d_rsp_valid}, 32'd0);
        drive(0, 0, 0, 0, 0, 0);
        chk("idle_no_rsp", {30'b0, if_rsp_valid, d_rsp_valid}, 32'd0);

        // Contested: fixed priority gives data first, fetch waits
        drive(1, 32'h0, 1, 0, 32'h10, 0);
`ifdef MEM_ARB_RR_EN
        chk("c_if_ready", {31'b0, if_req_ready}, 32'd0);
        chk("c_d_ready",  {31'b0, d_req_ready},  32'd1);
`else
        chk("c_if_ready", {31'b0, if_req_ready}, 32'd0);
        chk("c_d_ready",  {31'b0, d_req_ready},  32'd1);
`endif
        chk("c_mem_addr", mem_addr, 32'h4);
        drive(1, 32'h0, 0, 0, 0, 0);
        chk("c_d_rsp_valid", {31'b0, d_rsp_valid}, 32'd1);
        chk("c_d_rsp_data",  d_rsp_data, model[4]);
        chk("c_if_ready2",   {31'b0, if_req_ready}, 32'd1);
        chk("c_mem_addr2",   mem_addr, 32'h0);
        drive(0, 0, 0, 0, 0, 0);
        chk("c_if_rsp_valid", {31'b0, if_rsp_valid}, 32'd1);
        chk("c_if_rsp_data",  if_rsp_data, model[0]);

        // Store then load back
        drive(0, 0, 1, 1, 32'hC, 32'hDEAD_BEEF);
        model[3] = 32'hDEAD_BEEF;
        chk("s_mem_we",   {31'b0, mem_we}, 32'd1);
        chk("s_mem_addr", mem_addr, 32'h3);
        chk("s_wdata",    mem_wdata, 32'hDEAD_BEEF);
        drive(0, 0, 1, 0, 32'hC, 0);
        chk("s_rsp_valid", {31'b0, d_rsp_valid}, 32'd1);
        chk("s_rsp_data",  d_rsp_data, 32'd0);
        chk("l_mem_we",    {31'b0, mem_we}, 32'd0);
        drive(0, 0, 0, 0, 0, 0);
        chk("l_rsp_valid", {31'b0, d_rsp_valid}, 32'd1);
        chk("l_rsp_data",  d_rsp_data, model[3]);

        // Back-to-back fetches
        drive(1, 32'h0, 0, 0, 0, 0);
        chk("b_ready0", {31'b0, if_req_ready}, 32'd1);
        drive(1, 32'h4, 0, 0, 0, 0);
        chk("b_vld0",  {31'b0, if_rsp_valid}, 32'd1);
        chk("b_data0", if_rsp_data, model[0]);
        drive(1, 32'h8, 0, 0, 0, 0);
        chk("b_vld1",  {31'b0, if_rsp_valid}, 32'd1);
        chk("b_data1", if_rsp_data, model[1]);
        drive(0, 0, 0, 0, 0, 0);
        chk("b_vld2",  {31'b0, if_rsp_valid}, 32'd1);
        chk("b_data2", if_rsp_data, model[2]);
        drive(0, 0, 0, 0, 0, 0);
        chk("b_done",  {31'b0, if_rsp_valid}, 32'd0);

        // Reset right after a load grant discards its response
        drive(0, 0, 1, 0, 32'h10, 0);
        chk("r_d_ready", {31'b0, d_req_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        if_req_valid = 1'b1; d_req_valid = 1'b1; d_req_we = 1'b1;
        #1;
        chk("r_d_rsp_valid", {31'b0, d_rsp_valid}, 32'd0);
        chk("r_readies",     {30'b0, if_req_ready, d_req_ready}, 32'd0);
        chk("r_mem_we",      {31'b0, mem_we}, 32'd0);
        chk("r_rsp_data",    if_rsp_data | d_rsp_data, 32'd0);

        // Contested for 4 cycles straight out of reset
        for (int k = 0; k < 5; k++) begin
            logic exp_d, prev_d;
            @(negedge clk);
            rst = 1'b0;
            if (k < 4) begin
                if_req_valid = 1'b1; if_req_addr = 32'h18;
                d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'h14;
            end else begin
                if_req_valid = 1'b0; d_req_valid = 1'b0;
            end
            #1;
`ifdef MEM_ARB_RR_EN
            exp_d  = (k % 2) == 1;
            prev_d = ((k - 1) % 2) == 1;
`else
            exp_d  = 1'b1;
            prev_d = 1'b1;
`endif
            if (k < 4) begin
                chk($sformatf("rr_d_ready%0d", k),  {31'b0, d_req_ready},  {31'b0, exp_d});
                chk($sformatf("rr_if_ready%0d", k), {31'b0, if_req_ready}, {31'b0, !exp_d});
            end
            if (k == 0) begin
                chk("rr_no_rsp_after_rst", {30'b0, if_rsp_valid, d_rsp_valid}, 32'd0);
            end else if (prev_d) begin
                chk($sformatf("rr_d_rsp%0d", k), {31'b0, d_rsp_valid}, 32'd1);
                chk($sformatf("rr_d_dat%0d", k), d_rsp_data, model[5]);
            end else begin
                chk($sformatf("rr_if_rsp%0d", k), {31'b0, if_rsp_valid}, 32'd1);
                chk($sformatf("rr_if_dat%0d", k), if_rsp_data, model[6]);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port if_req_valid, input, 1, instruction fetch request.
REQ-004 SHALL have port if_req_addr, input, 32, fetch byte address.
REQ-005 SHALL have port if_req_ready, output, 1, fetch request accepted this cycle.
REQ-006 SHALL have port if_rsp_valid, output, 1, fetch data valid.
REQ-007 SHALL have port if_rsp_data, output, 32, fetched instruction word.
REQ-008 SHALL have port d_req_valid, input, 1, data request.
REQ-009 SHALL have port d_req_we, input, 1, 1 = store, 0 = load.
REQ-010 SHALL have port d_req_addr, input, 32, data byte address.
REQ-011 SHALL have port d_req_wdata, input, 32, store data.
REQ-012 SHALL have port d_req_ready, output, 1, data request accepted this cycle.
REQ-013 SHALL have port d_rsp_valid, output, 1, load data valid or store acknowledge.
REQ-014 SHALL have port d_rsp_data, output, 32, load data; 0 for store acknowledge.
REQ-015 SHALL have port mem_addr, output, 32, word address to the shared memory.
REQ-016 SHALL have port mem_we, output, 1, memory write strobe.
REQ-017 SHALL have port mem_wdata, output, 32, memory write data.
REQ-018 SHALL have port mem_rdata, input, 32, memory read data, valid the cycle after the address is presented (memory registers the address on posedge clk).

Function
REQ-019 SHALL accept at most one request per cycle; a request is accepted when valid and ready are both high in the same cycle.
REQ-020 SHALL drive ready combinationally: the granted requester's ready is 1, the other's is 0; both are 0 when neither is valid.
REQ-021 SHALL present the granted request combinationally: mem_addr = addr >> 2 (addr[1:0] ignored), mem_we = d_req_we only when data is granted, mem_wdata = d_req_wdata.
REQ-022 SHALL register the grant owner and the write flag at acceptance; in cycle N+1 it SHALL assert exactly one of if_rsp_valid or d_rsp_valid for one cycle.
REQ-023 SHALL route mem_rdata to the response data of the owner in cycle N+1; a store response SHALL carry d_rsp_data = 0.
REQ-024 SHALL sustain back-to-back acceptance: a new grant in cycle N+1 SHALL be allowed while the response for cycle N is delivered (throughput 1 per cycle).
REQ-025 SHALL keep rsp_valid low in any cycle that follows a cycle with no acceptance.
REQ-026 Arbitration SHALL use fixed priority by default: data beats fetch when both are valid.
REQ-027 A requester SHALL hold valid and its request fields stable until accepted; the arbiter SHALL NOT latch unaccepted requests.

Reset
REQ-028 While rst is high, all ready, rsp_valid and mem_we outputs SHALL be 0, and rsp_data outputs SHALL be 0.
REQ-029 Reset asserted mid-transaction SHALL discard the outstanding response; no rsp_valid SHALL follow release of reset.
REQ-030 After reset, the round-robin last-grant register (when compiled in) SHALL be reset to data, so fetch wins the first contested cycle.

Configuration
REQ-031 Macro MEM_ARB_RR_EN: when defined, contested cycles SHALL grant the requester not granted on the most recent contested or uncontested grant (round-robin; the last-grant register updates on every acceptance).
REQ-032 When MEM_ARB_RR_EN is undefined, REQ-026 fixed priority SHALL apply and no last-grant register SHALL exist.

Verification
REQ-033 Fetch only, if_req_addr=0x8 -> mem_addr=0x2 in the same cycle; the next cycle if_rsp_valid=1 and if_rsp_data=mem[2].
REQ-034 Both valid: fetch 0x0 and load 0x10 without the macro -> d_req_ready=1, if_req_ready=0; the next cycle d_rsp_data=mem[4]; the fetch is granted the following cycle.
REQ-035 Store d_req_addr=0xC, wdata=0xDEADBEEF -> mem_we=1, mem_addr=0x3; the next cycle d_rsp_valid=1 with d_rsp_data=0; a subsequent load from 0xC returns 0xDEADBEEF.
REQ-036 Both valid continuously for 4 cycles with MEM_ARB_RR_EN -> grants are fetch, data, fetch, data; each response arrives one cycle after its grant.
REQ-037 rst pulsed in the cycle after a load grant -> no d_rsp_valid is asserted; all outputs are 0 during reset.
REQ-038 Back-to-back fetches 0x0, 0x4, 0x8 -> if_rsp_valid is high for 3 consecutive cycles with mem[0], mem[1], mem[2].
